// File: rtl/rv_pkg.sv
// Shared RISC-V core constants: load funct3 encodings and write-back source slots.
package rv_pkg;

    // Load size/sign encodings carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Write-back result source slots
    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_MEM = 1;
    localparam int unsigned WB_SRC_PC4 = 2;
    localparam int unsigned WB_SRC_IMM = 3;

endpackage

// File: rtl/wb_stage_load_fmt.sv
// Combinational load-data aligner and sign/zero extender.
module load_fmt
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned LSBW = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [2:0]      i_funct3,
    input  logic [LSBW-1:0] i_addr_lsb,
    output logic [XLEN-1:0] o_data
);

    // Sub-access offsets: drop the address bits below the access size
    logic [LSBW-1:0] w_lsb_h;
    logic [LSBW-1:0] w_lsb_w;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_word;

    assign w_lsb_h = i_addr_lsb & ~LSBW'(1);
    assign w_lsb_w = i_addr_lsb & ~LSBW'(3);
    assign w_byte  = 8'(i_word >> {i_addr_lsb, 3'b000});
    assign w_half  = 16'(i_word >> {w_lsb_h, 3'b000});
    assign w_word  = 32'(i_word >> {w_lsb_w, 3'b000});

    // Select and extend according to funct3; unknown encodings pass the raw word
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_LB:  o_data = XLEN'($signed(w_byte));
            F3_LBU: o_data = XLEN'(w_byte);
            F3_LH:  o_data = XLEN'($signed(w_half));
            F3_LHU: o_data = XLEN'(w_half);
            F3_LW:  o_data = XLEN'($signed(w_word));
            F3_LWU: o_data = (XLEN == 64) ? XLEN'(w_word) : i_word;
            F3_LD:  o_data = i_word;
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: W register, result select, register-file write enable,
// retired-instruction counter and sticky illegal-select flag.
module wb_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NSRC = 4,
    parameter int unsigned SELW = $clog2(NSRC),
    parameter int unsigned CNTW = 64,
    parameter int unsigned LSBW = $clog2(XLEN/8)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_M,
    input  logic               reg_write_M,
    input  logic [4:0]         rd_M,
    input  logic [SELW-1:0]    result_src_M,
    input  logic [2:0]         funct3_M,
    input  logic [LSBW-1:0]    addr_lsb_M,
    input  logic [NSRC*XLEN-1:0] src_data_M,
    input  logic               stall_W,
    input  logic               flush_W,
    output logic               valid_W,
    output logic [4:0]         rd_W,
    output logic               we_W,
    output logic [XLEN-1:0]    result_W,
    output logic [CNTW-1:0]    instret,
    output logic               sel_err
);

    logic                 r_valid;
    logic                 r_reg_write;
    logic [4:0]           r_rd;
    logic [SELW-1:0]      r_src;
    logic [2:0]           r_f3;
    logic [LSBW-1:0]      r_lsb;
    logic [NSRC*XLEN-1:0] r_data;
    logic [CNTW-1:0]      r_instret;
    logic                 r_sel_err;

    logic                 w_retire;
    logic                 w_sel_bad;
    logic [XLEN-1:0]      w_load;
    logic [XLEN-1:0]      w_result;

    // A flush overwrites W even under stall, so the resident instruction
    // leaves W on that edge and must retire then rather than be lost.
    assign w_retire  = r_valid & (~stall_W | flush_W);
    assign w_sel_bad = ({1'b0, r_src} >= (SELW+1)'(NSRC));

    // W register: flush inserts a zeroed bubble, stall holds, else capture M
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_src       <= '0;
            r_f3        <= '0;
            r_lsb       <= '0;
            r_data      <= '0;
        end else if (flush_W) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_src       <= '0;
            r_f3        <= '0;
            r_lsb       <= '0;
            r_data      <= '0;
        end else if (!stall_W) begin
            r_valid     <= valid_M;
            r_reg_write <= reg_write_M;
            r_rd        <= rd_M;
            r_src       <= result_src_M;
            r_f3        <= funct3_M;
            r_lsb       <= addr_lsb_M;
            r_data      <= src_data_M;
        end
    end

    // Retire counter and sticky out-of-range select flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
            r_sel_err <= 1'b0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNTW'(1);
            if (w_sel_bad) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    load_fmt #(
        .XLEN (XLEN),
        .LSBW (LSBW)
    ) u_load_fmt (
        .i_word     (r_data[WB_SRC_MEM*XLEN +: XLEN]),
        .i_funct3   (r_f3),
        .i_addr_lsb (r_lsb),
        .o_data     (w_load)
    );

    // Result mux: the memory slot goes through the load formatter, bad selects yield 0
    always_comb begin
        w_result = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (r_src == SELW'(k)) begin
                w_result = (k == WB_SRC_MEM) ? w_load : r_data[k*XLEN +: XLEN];
            end
        end
    end

    assign valid_W  = r_valid;
    assign rd_W     = r_rd;
    assign we_W     = w_retire & r_reg_write & (r_rd != 5'd0);
    assign result_W = w_result;
    assign instret  = r_instret;
    assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: default NSRC=4 instance plus an NSRC=3 instance.
module tb_wb_stage;
    import rv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_M;
    logic        reg_write_M;
    logic [4:0]  rd_M;
    logic [1:0]  result_src_M;
    logic [2:0]  funct3_M;
    logic [1:0]  addr_lsb_M;
    logic [127:0] src_data_M;
    logic        stall_W;
    logic        flush_W;
    logic        valid_W;
    logic [4:0]  rd_W;
    logic        we_W;
    logic [31:0] result_W;
    logic [63:0] instret;
    logic        sel_err;

    logic        valid_M3;
    logic [4:0]  rd_M3;
    logic [1:0]  result_src_M3;
    logic [95:0] src_data_M3;
    logic        valid_W3;
    logic [4:0]  rd_W3;
    logic        we_W3;
    logic [31:0] result_W3;
    logic [63:0] instret3;
    logic        sel_err3;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ret  = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] res;
    } exp_t;
    exp_t q[$];

    wb_stage u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_M      (valid_M),
        .reg_write_M  (reg_write_M),
        .rd_M         (rd_M),
        .result_src_M (result_src_M),
        .funct3_M     (funct3_M),
        .addr_lsb_M   (addr_lsb_M),
        .src_data_M   (src_data_M),
        .stall_W      (stall_W),
        .flush_W      (flush_W),
        .valid_W      (valid_W),
        .rd_W         (rd_W),
        .we_W         (we_W),
        .result_W     (result_W),
        .instret      (instret),
        .sel_err      (sel_err)
    );

    wb_stage #(.NSRC(3)) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_M      (valid_M3),
        .reg_write_M  (reg_write_M),
        .rd_M         (rd_M3),
        .result_src_M (result_src_M3),
        .funct3_M     (funct3_M),
        .addr_lsb_M   (addr_lsb_M),
        .src_data_M   (src_data_M3),
        .stall_W      (stall_W),
        .flush_W      (flush_W),
        .valid_W      (valid_W3),
        .rd_W         (rd_W3),
        .we_W         (we_W3),
        .result_W     (result_W3),
        .instret      (instret3),
        .sel_err      (sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one M bundle for one cycle; push the expected W response when it will be captured
    task automatic issue(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] val,
                         input logic [31:0] exp_res, input bit fl, input bit st);
        logic [127:0] sd;
        exp_t e;
        for (int k = 0; k < 4; k++) sd[k*32 +: 32] = 32'h5A5A_0000 | 32'(k);
        sd[src*32 +: 32] = val;
        valid_M      = v;
        reg_write_M  = rw;
        rd_M         = rd;
        result_src_M = src;
        funct3_M     = f3;
        addr_lsb_M   = lsb;
        src_data_M   = sd;
        flush_W      = fl;
        stall_W      = st;
        if (v && !fl && !st) begin
            e.rd  = rd;
            e.we  = rw && (rd != 5'd0);
            e.res = exp_res;
            q.push_back(e);
        end
        step();
    endtask

    task automatic idle(input bit fl, input bit st);
        issue(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, fl, st);
    endtask

    // Monitor: compare W outputs against the scoreboard head, pop on retire
    initial begin
        exp_t e;
        bit   ret;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (valid_W) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 64'(valid_W), 64'd0);
                    end else begin
                        e   = q[0];
                        ret = !stall_W || flush_W;
                        chk("rd_W", 64'(rd_W), 64'(e.rd));
                        chk("result_W", 64'(result_W), 64'(e.res));
                        chk("we_W", 64'(we_W), 64'(e.we && ret));
                        if (ret) begin
                            chk("instret", instret, 64'(n_ret));
                            n_ret++;
                            void'(q.pop_front());
                        end
                    end
                end else begin
                    chk("we_W_idle", 64'(we_W), 64'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid_M = 1'b0; reg_write_M = 1'b0; rd_M = '0; result_src_M = '0;
        funct3_M = '0; addr_lsb_M = '0; src_data_M = '0; stall_W = 1'b0; flush_W = 1'b0;
        valid_M3 = 1'b0; rd_M3 = '0; result_src_M3 = '0;
        src_data_M3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        #2;
        chk("rst_valid_W", 64'(valid_W), 64'd0);
        chk("rst_rd_W", 64'(rd_W), 64'd0);
        chk("rst_we_W", 64'(we_W), 64'd0);
        chk("rst_result_W", 64'(result_W), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_sel_err", 64'(sel_err), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        //     v  rw rd     src   f3      lsb   value          expected
        issue(1, 1, 5'd1,  2'd1, F3_LB,  2'd3, 32'h80FF_1234, 32'hFFFF_FF80, 0, 0);
        issue(1, 1, 5'd2,  2'd1, F3_LBU, 2'd3, 32'h80FF_1234, 32'h0000_0080, 0, 0);
        issue(1, 1, 5'd3,  2'd1, F3_LH,  2'd2, 32'h8001_7FFF, 32'hFFFF_8001, 0, 0);
        issue(1, 1, 5'd4,  2'd1, F3_LH,  2'd0, 32'h8001_7FFF, 32'h0000_7FFF, 0, 0);
        issue(1, 1, 5'd0,  2'd0, 3'd0,   2'd0, 32'h0000_1234, 32'h0000_1234, 0, 0);
        issue(1, 1, 5'd6,  2'd2, 3'd0,   2'd0, 32'h0000_0104, 32'h0000_0104, 0, 0);
        issue(1, 1, 5'd7,  2'd3, 3'd0,   2'd0, 32'hABCD_E000, 32'hABCD_E000, 0, 0);
        issue(1, 0, 5'd8,  2'd0, 3'd0,   2'd0, 32'h0000_0800, 32'h0000_0800, 0, 0);
        issue(1, 1, 5'd9,  2'd1, F3_LW,  2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
        issue(1, 1, 5'd13, 2'd1, F3_LHU, 2'd2, 32'h8001_7FFF, 32'h0000_8001, 0, 0);
        issue(1, 1, 5'd14, 2'd1, F3_LB,  2'd1, 32'h0000_7F00, 32'h0000_007F, 0, 0);

        // ADD to x5 held by a three-cycle stall, then released
        issue(1, 1, 5'd5,  2'd0, 3'd0,   2'd0, 32'h0000_0055, 32'h0000_0055, 0, 0);
        idle(0, 1);
        idle(0, 1);
        idle(0, 1);
        idle(0, 0);

        // Flush and stall together: resident instruction retires once, incoming one dies
        issue(1, 1, 5'd10, 2'd0, 3'd0,   2'd0, 32'h0000_00AA, 32'h0000_00AA, 0, 0);
        issue(1, 1, 5'd11, 2'd0, 3'd0,   2'd0, 32'h0000_00BB, 32'h0000_00BB, 1, 1);
        chk("flush_valid_W", 64'(valid_W), 64'd0);
        idle(0, 0);
        idle(0, 0);
        chk("instret_total", instret, 64'd13);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        chk("sel_err_nsrc4", 64'(sel_err), 64'd0);

        // NSRC=3 instance: out-of-range select retires with zero result and sets the sticky flag
        valid_M3 = 1'b1; rd_M3 = 5'd12; result_src_M3 = 2'd3; reg_write_M = 1'b1;
        step();
        valid_M3 = 1'b0; reg_write_M = 1'b0;
        chk("n3_valid_W", 64'(valid_W3), 64'd1);
        chk("n3_result_W", 64'(result_W3), 64'd0);
        chk("n3_sel_err_before", 64'(sel_err3), 64'd0);
        step();
        chk("n3_sel_err", 64'(sel_err3), 64'd1);
        chk("n3_instret", instret3, 64'd1);
        step();
        step();
        chk("n3_sel_err_sticky", 64'(sel_err3), 64'd1);

        // Asynchronous reset mid-cycle, checked before any further clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_n3_valid_W", 64'(valid_W3), 64'd0);
        chk("arst_n3_rd_W", 64'(rd_W3), 64'd0);
        chk("arst_n3_we_W", 64'(we_W3), 64'd0);
        chk("arst_n3_result_W", 64'(result_W3), 64'd0);
        chk("arst_n3_instret", instret3, 64'd0);
        chk("arst_n3_sel_err", 64'(sel_err3), 64'd0);
        chk("arst_instret", instret, 64'd0);
        chk("arst_valid_W", 64'(valid_W), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
